// File: rtl/serial_bit_tx.sv
// rtl/serial_bit_tx.sv - MSB-first parallel-to-serial transmitter with post-word idle gap
//
// Ports:
//   clk      rising-edge clock
//   n_rst    synchronous active-low reset
//   start    transmit request, honoured only in IDLE
//   din      parallel word, captured on the accepted start edge
//   x        serial data, MSB first, 0 whenever x_valid is low
//   x_valid  high while x carries a data bit
//   busy     high in SHIFT and GAP
//   done     one-cycle pulse in the cycle after the last bit
module serial_bit_tx #(
    parameter int DATA_W  = 8,
    parameter int GAP_CYC = 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    output logic              x,
    output logic              x_valid,
    output logic              busy,
    output logic              done
);

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DATA_W - 1);
    // GAP is entered only when GAP_CYC > 0; the load value counts down to 0
    // so the state lasts exactly GAP_CYC cycles.
    localparam logic [3:0]        GAP_LOAD = 4'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DATA_W-1:0]  shift_reg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [3:0]         gap_cnt;
    logic               done_q;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            done_q    <= 1'b0;
        end else begin
            state  <= state_nxt;
            // done marks the cycle following the last-bit edge, which is
            // either the first GAP cycle or an IDLE cycle.
            done_q <= (state == SHIFT) && (bit_cnt == '0);
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg <= din;
                        bit_cnt   <= CNT_LOAD;
                    end
                end
                SHIFT: begin
                    shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else begin
                        gap_cnt <= GAP_LOAD;
                    end
                end
                GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (bit_cnt == '0) state_nxt = (GAP_CYC > 0) ? GAP : IDLE;
            GAP:     if (gap_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs depend only on registered state, never on start or din.
    always_comb begin
        x       = 1'b0;
        x_valid = 1'b0;
        busy    = 1'b0;
        done    = done_q;
        if (state == SHIFT) begin
            x       = shift_reg[DATA_W-1];
            x_valid = 1'b1;
        end
        if (state != IDLE) begin
            busy = 1'b1;
        end
    end

endmodule
